draw_scene_gen: RTL and testbench

- Parametrised successor to the main-menu scene drawer for the LED matrix.
- Renders the START, SONG_SELECT, GAME_PLAY and GAME_OVER frames into a flat registered pixel map, with WIDTH × HEIGHT set by parameters.
- Adds a tick prescaler, a blink generator, a scrolling song banner and a column-wipe transition on every state change.
- Sits between the game-state FSM and the matrix scan driver.

---
 rtl/draw_scene_gen.sv | 204 ++++++++++++++++++++
 tb/tb_draw_scene_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_scene_gen.sv
`default_nettype none
// ============================================================================
// Module   : draw_scene_gen
// Purpose  : Renders the START / SONG_SELECT / GAME_PLAY / GAME_OVER scenes
//            for the LED matrix into a registered, flat RGB pixel map. The map
//            is refreshed once per animation tick. A column wipe runs on
//            every game-state change.
// Ports    : clk           - system clock
//            rst           - synchronous, active-high reset
//            current_state - 00 START, 01 SONG_SELECT, 10 GAME_PLAY,
//                            11 GAME_OVER
//            selected_song - song index, sampled live
//            menuMap       - frame; bit ((y*WIDTH+x)*3+c), c: 0 R, 1 G, 2 B
//            frame_update  - one-cycle pulse on each menuMap load
//            busy          - high while a wipe transition is in progress
// Revision : 1.0 - initial release
// ============================================================================
module draw_scene_gen #(
    parameter int WIDTH       = 64,
    parameter int HEIGHT      = 32,
    parameter int TICK_DIV    = 1000000,
    parameter int BLINK_TICKS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  current_state,
    input  logic [1:0]                  selected_song,
    output logic [WIDTH*HEIGHT*3-1:0]   menuMap,
    output logic                        frame_update,
    output logic                        busy
);

    localparam int c_NBITS = WIDTH * HEIGHT * 3;
    localparam int c_AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_CW    = $clog2(TICK_DIV);
    localparam int c_BW    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [c_AW-1:0] c_COL_LAST   = c_AW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_PRESC_LAST = c_CW'(TICK_DIV - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_TICKS - 1);

    localparam logic [1:0] c_ST_START  = 2'b00;
    localparam logic [1:0] c_ST_SELECT = 2'b01;
    localparam logic [1:0] c_ST_PLAY   = 2'b10;

    localparam logic [2:0] c_BLACK = 3'b000;
    localparam logic [2:0] c_RED   = 3'b001;
    localparam logic [2:0] c_GREEN = 3'b010;
    localparam logic [2:0] c_BLUE  = 3'b100;
    localparam logic [2:0] c_WHITE = 3'b111;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [c_CW-1:0]    presc_q,        presc_d;
    logic [c_AW-1:0]    anim_pos_q,     anim_pos_d;
    logic [c_BW-1:0]    blink_cnt_q,    blink_cnt_d;
    logic               blink_q,        blink_d;
    logic [c_AW-1:0]    wipe_col_q,     wipe_col_d;
    logic               busy_q,         busy_d;
    logic [1:0]         prev_state_q,   prev_state_d;
    logic [c_NBITS-1:0] menu_map_q,     menu_map_d;
    logic               frame_update_q, frame_update_d;

    logic               w_tick;
    logic               w_change;
    logic               w_mask_on;
    logic [c_AW-1:0]    w_mask_col;
    logic [2:0]         w_song_rgb;
    wire  [c_NBITS-1:0] w_frame;

    assign w_tick    = (presc_q == c_PRESC_LAST);
    assign w_change  = (current_state != prev_state_q);
    // A change in this cycle wins over an in-flight wipe: the frame rendered
    // on a coincident tick already belongs to the new wipe, starting at col 0.
    assign w_mask_on  = busy_q | w_change;
    assign w_mask_col = w_change ? '0 : wipe_col_q;

    always_comb begin
        w_song_rgb = c_WHITE;
        case (selected_song)
            2'd0:    w_song_rgb = c_RED;
            2'd1:    w_song_rgb = c_GREEN;
            2'd2:    w_song_rgb = c_BLUE;
            default: w_song_rgb = c_WHITE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-pixel scene renderer
    // ------------------------------------------------------------------
    for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
        for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
            localparam int c_IDX = (gy * WIDTH + gx) * 3;

            logic [2:0] w_pix;
            logic       w_band;

            // Banner stripes: period 8 columns, scrolling with anim_pos.
            // 3-bit arithmetic gives the modulo-8 wrap for free.
            assign w_band = ((3'(gx) + 3'(anim_pos_q)) < 3'd4);

            always_comb begin
                w_pix = c_BLACK;
                case (current_state)
                    c_ST_START: begin
                        if (anim_pos_q == c_AW'(gx)) w_pix = c_GREEN;
                    end
                    c_ST_SELECT: begin
                        if ((gy < HEIGHT / 2) && w_band) w_pix = w_song_rgb;
                        if ((gy == HEIGHT - 1) && blink_q) w_pix = c_WHITE;
                    end
                    c_ST_PLAY: begin
                        if (gy == HEIGHT - 1) w_pix = c_WHITE;
                    end
                    default: begin
                        if (blink_q) w_pix = c_RED;
                    end
                endcase
                if (w_mask_on && (c_AW'(gx) > w_mask_col)) w_pix = c_BLACK;
            end

            assign w_frame[c_IDX +: 3] = w_pix;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        presc_d        = presc_q + c_CW'(1);
        anim_pos_d     = anim_pos_q;
        blink_cnt_d    = blink_cnt_q;
        blink_d        = blink_q;
        wipe_col_d     = wipe_col_q;
        busy_d         = busy_q;
        prev_state_d   = current_state;
        menu_map_d     = menu_map_q;
        frame_update_d = 1'b0;

        if (w_tick) begin
            presc_d        = '0;
            menu_map_d     = w_frame;
            frame_update_d = 1'b1;
            anim_pos_d     = (anim_pos_q == c_COL_LAST) ? '0 : anim_pos_q + c_AW'(1);
            if (blink_cnt_q == c_BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + c_BW'(1);
            end
        end

        // Wipe progress: advance after every rendered wipe frame; the frame
        // drawn with the last column visible completes the transition.
        if (w_mask_on) begin
            if (w_tick) begin
                if (w_mask_col == c_COL_LAST) begin
                    busy_d     = 1'b0;
                    wipe_col_d = '0;
                end else begin
                    busy_d     = 1'b1;
                    wipe_col_d = w_mask_col + c_AW'(1);
                end
            end else if (w_change) begin
                busy_d     = 1'b1;
                wipe_col_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q        <= '0;
            anim_pos_q     <= '0;
            blink_cnt_q    <= '0;
            blink_q        <= 1'b0;
            wipe_col_q     <= '0;
            busy_q         <= 1'b0;
            prev_state_q   <= 2'b00;
            menu_map_q     <= '0;
            frame_update_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            anim_pos_q     <= anim_pos_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_q        <= blink_d;
            wipe_col_q     <= wipe_col_d;
            busy_q         <= busy_d;
            prev_state_q   <= prev_state_d;
            menu_map_q     <= menu_map_d;
            frame_update_q <= frame_update_d;
        end
    end

    assign menuMap      = menu_map_q;
    assign frame_update = frame_update_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_scene_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_scene_gen
// Purpose  : Directed self-checking bench for draw_scene_gen with an 8x4
//            matrix, 4-cycle ticks and 2-tick blink half-period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_scene_gen;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NB = W * H * 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    current_state = 2'b00;
    logic [1:0]    selected_song = 2'b00;
    logic [NB-1:0] menuMap;
    logic          frame_update;
    logic          busy;

    int n_checks   = 0;
    int n_failures = 0;
    int fc         = 0;   // frames rendered since the last reset
    bit busy_dropped = 1'b0;

    draw_scene_gen #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .TICK_DIV    (4),
        .BLINK_TICKS (2)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .selected_song (selected_song),
        .menuMap       (menuMap),
        .frame_update  (frame_update),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next frame_update; returns the number of edges taken.
    task automatic wait_frame(output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        while (!done && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) busy_dropped = 1'b1;
            if (frame_update) done = 1'b1;
        end
        if (!done) check("frame_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int blink_of(input int f);
        return (f / 2) % 2;
    endfunction

    // Expected frame from the scene description; columns above mcol black.
    function automatic logic [NB-1:0] exp_frame(input int st, input int song,
                                                input int anim, input int blk,
                                                input int mcol);
        logic [NB-1:0] f;
        logic [2:0]    rgb;
        f = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rgb = 3'b000;
                case (st)
                    0: if (x == anim) rgb = 3'b010;
                    1: begin
                        if (y < H / 2 && ((x + anim) % 8) < 4)
                            rgb = (song == 3) ? 3'b111 : 3'(1 << song);
                        if (y == H - 1 && blk == 1) rgb = 3'b111;
                    end
                    2: if (y == H - 1) rgb = 3'b111;
                    default: rgb = (blk == 1) ? 3'b001 : 3'b000;
                endcase
                if (x > mcol) rgb = 3'b000;
                f[(y * W + x) * 3 +: 3] = rgb;
            end
        end
        return f;
    endfunction

    initial begin
        int n;
        logic [NB-1:0] col0, col1, all_red;
        logic [7:0] row0_g;

        col0 = '0; col0[1] = 1'b1; col0[25] = 1'b1; col0[49] = 1'b1; col0[73] = 1'b1;
        col1 = '0; col1[4] = 1'b1; col1[28] = 1'b1; col1[52] = 1'b1; col1[76] = 1'b1;
        all_red = '0;
        for (int p = 0; p < W * H; p++) all_red[p * 3] = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("reset_map", menuMap, '0);
        check("reset_fu", frame_update, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // ---------------- 1: START ----------------
        wait_frame(n);
        check("t1_first_tick_lat", n, 4);
        check("t1_col0", menuMap, col0);
        step();
        check("t1_fu_pulse", frame_update, 0);
        wait_frame(n);
        check("t1_col1", menuMap, col1);
        check("t1_busy", busy, 0);
        fc = 2;

        // ---------------- 2: START -> SONG_SELECT, song 1 ----------------
        current_state = 2'b01;
        selected_song = 2'd1;
        step();
        check("t2_busy_rise", busy, 1);
        for (int i = 0; i < W; i++) begin
            wait_frame(n);
            check($sformatf("t2_wipe_frame%0d", i), menuMap,
                  exp_frame(1, 1, fc % 8, blink_of(fc), i));
            check($sformatf("t2_busy%0d", i), busy, (i < W - 1) ? 1 : 0);
            fc++;
        end
        // Full frame rendered with anim_pos=1: row 0 green at x=0,1,2,7
        for (int x = 0; x < W; x++) row0_g[x] = menuMap[x * 3 + 1];
        check("t2_row0_green", row0_g, 8'b1000_0111);

        // ---------------- 3: SONG_SELECT song 3, cursor blink ----------------
        selected_song = 2'd3;
        for (int i = 0; i < 4; i++) begin
            wait_frame(n);
            check($sformatf("t3_cursor%0d", i), menuMap[95:72],
                  (i < 2) ? 24'hFF_FFFF : 24'h00_0000);
            check($sformatf("t3_busy%0d", i), busy, 0);
            fc++;
        end

        // ---------------- 4: GAME_OVER steady ----------------
        current_state = 2'b11;
        for (int i = 0; i < W; i++) begin
            wait_frame(n);
            fc++;
        end
        check("t4_wipe_done", busy, 0);
        for (int i = 0; i < 4; i++) begin
            selected_song = 2'(i);
            wait_frame(n);
            check($sformatf("t4_over%0d", i), menuMap, (i < 2) ? all_red : '0);
            check($sformatf("t4_busy%0d", i), busy, 0);
            fc++;
        end

        // ---------------- 5: wipe restart ----------------
        current_state = 2'b10;
        step();
        check("t5_busy_rise", busy, 1);
        busy_dropped = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_frame(n);
            check($sformatf("t5_play%0d", i), menuMap,
                  exp_frame(2, 3, fc % 8, blink_of(fc), i));
            fc++;
        end
        current_state = 2'b11;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) check("t5_busy_held", busy_dropped, 0);
            wait_frame(n);
            check($sformatf("t5_over%0d", i), menuMap,
                  exp_frame(3, 3, fc % 8, blink_of(fc), i));
            fc++;
        end
        check("t5_busy_fall", busy, 0);

        // ---------------- 6: reset mid-wipe ----------------
        current_state = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wait_frame(n);
            check($sformatf("t6_start%0d", i), menuMap,
                  exp_frame(0, 3, fc % 8, blink_of(fc), i));
            fc++;
        end
        step();
        rst = 1'b1;
        step();
        check("t6_rst_map", menuMap, '0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fu", frame_update, 0);
        rst = 1'b0;
        wait_frame(n);
        check("t6_restart_lat", n, 4);
        check("t6_col0", menuMap, col0);
        check("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
